// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-to-1 registered mux with round-robin or fixed select and valid/ready handshake
module rr_arb_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready,
    output logic                     sel_err
);
    logic [SEL_W-1:0] rr_ptr, rr_g, g;
    logic             rr_hit, sel_ok, gnt, load, xfer;

    // round-robin search from rr_ptr upward; descending scan lets the nearest valid channel win
    always_comb begin
        int idx;
        rr_hit = 1'b0;
        rr_g   = '0;
        idx    = 0;
        for (int k = NUM_CH-1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (in_valid[idx]) begin
                rr_hit = 1'b1;
                rr_g   = SEL_W'(idx);
            end
        end
    end

    // grant selection, ready generation and transfer detection
    always_comb begin
        sel_ok   = int'(sel) < NUM_CH;
        gnt      = mode ? sel_ok : rr_hit;
        g        = !gnt ? '0 : mode ? sel : rr_g;
        load     = ~out_valid | out_ready;
        in_ready = (rst_n && gnt && load) ? NUM_CH'(1) << g : '0;
        xfer     = |(in_ready & in_valid);
    end

    // output register, round-robin pointer and select error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            sel_err <= mode & ~sel_ok;
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[g*DATA_W +: DATA_W];
                out_ch    <= g;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && !mode)
                rr_ptr <= (int'(g) == NUM_CH-1) ? '0 : g + 1'b1;
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed self-checking bench for rr_arb_mux (4-channel and 3-channel instances)
module tb_rr_arb_mux;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_mode, b_mode, a_ordy, b_ordy;
    logic [1:0]  a_sel, b_sel;
    logic [3:0]  a_ivld, a_irdy;
    logic [2:0]  b_ivld, b_irdy;
    logic [31:0] a_idata;
    logic [23:0] b_idata;
    logic        a_ovld, b_ovld, a_err, b_err;
    logic [7:0]  a_odata, b_odata;
    logic [1:0]  a_och, b_och;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.NUM_CH(4), .DATA_W(8), .SEL_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
        .in_valid(a_ivld), .in_data(a_idata), .in_ready(a_irdy),
        .out_valid(a_ovld), .out_data(a_odata), .out_ch(a_och),
        .out_ready(a_ordy), .sel_err(a_err)
    );

    rr_arb_mux #(.NUM_CH(3), .DATA_W(8), .SEL_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
        .in_valid(b_ivld), .in_data(b_idata), .in_ready(b_irdy),
        .out_valid(b_ovld), .out_data(b_odata), .out_ch(b_och),
        .out_ready(b_ordy), .sel_err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        chk({tag, "_vld"}, a_ovld, v);
        chk({tag, "_data"}, a_odata, d);
        chk({tag, "_ch"}, a_och, c);
    endtask

    initial begin
        rst_n   = 1'b0;
        a_mode  = 1'b0;
        a_sel   = 2'd0;
        a_ivld  = 4'b1111;
        a_ordy  = 1'b1;
        a_idata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b_mode  = 1'b0;
        b_sel   = 2'd0;
        b_ivld  = 3'b111;
        b_ordy  = 1'b1;
        b_idata = {8'hB2, 8'hB1, 8'hB0};
        // T1 reset with all channels valid
        tick();
        tick();
        chk_out("t1", 1'b0, 8'h00, 2'd0);
        chk("t1_rdy", a_irdy, 4'b0000);
        chk("t1_err", a_err, 1'b0);
        // T2 round-robin fairness, one word per clock
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #0;
            chk("t2_rdy", a_irdy, 32'(1) << (i % 4));
            tick();
            chk_out("t2", 1'b1, 8'(8'hA0 + i % 4), 2'(i % 4));
        end
        // T3 skip and wrap with rr_ptr=1: grants 3,0,3,0
        a_ivld = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_rdy", a_irdy, (i % 2 == 0) ? 32'b1000 : 32'b0001);
            tick();
            chk_out("t3", 1'b1, (i % 2 == 0) ? 8'hA3 : 8'hA0, (i % 2 == 0) ? 2'd3 : 2'd0);
        end
        // T4 backpressure holds the word; release loads next word the same clock
        a_ivld = 4'b1111;
        a_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_rdy_hold", a_irdy, 4'b0000);
            tick();
            chk_out("t4_hold", 1'b1, 8'hA0, 2'd0);
        end
        a_ordy = 1'b1;
        #1;
        chk("t4_rdy_rel", a_irdy, 4'b0010);
        tick();
        chk_out("t4_rel", 1'b1, 8'hA1, 2'd1);
        // T5 fixed mode: only ch2 transfers
        a_mode = 1'b1;
        a_sel  = 2'd2;
        a_ivld = 4'b0111;
        #1;
        chk("t5_rdy", a_irdy, 4'b0100);
        tick();
        chk_out("t5_a", 1'b1, 8'hA2, 2'd2);
        tick();
        chk_out("t5_b", 1'b1, 8'hA2, 2'd2);
        a_ivld = 4'b0011;
        #1;
        chk("t5_rdy_novld", a_irdy, 4'b0100);
        tick();
        chk_out("t5_drain", 1'b0, 8'hA2, 2'd2);
        a_sel = 2'd3;
        tick();
        chk("t5_err_full", a_err, 1'b0);
        // back to round-robin: pointer must still be 2
        a_mode = 1'b0;
        a_ivld = 4'b1111;
        #1;
        chk("t5_ptr_rdy", a_irdy, 4'b0100);
        tick();
        chk_out("t5_ptr", 1'b1, 8'hA2, 2'd2);
        // reset mid-operation discards the held word
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rdy", a_irdy, 4'b0000);
        tick();
        chk_out("rst_mid", 1'b0, 8'h00, 2'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_ptr", a_irdy, 4'b0001);
        // T6 sel_err on the 3-channel instance
        b_mode = 1'b1;
        b_sel  = 2'd3;
        #1;
        chk("t6_rdy_bad", b_irdy, 3'b000);
        chk("t6_err_pre", b_err, 1'b0);
        tick();
        chk("t6_err_set", b_err, 1'b1);
        chk("t6_vld_bad", b_ovld, 1'b0);
        b_sel = 2'd1;
        #1;
        chk("t6_rdy_ok", b_irdy, 3'b010);
        chk("t6_err_hold", b_err, 1'b1);
        tick();
        chk("t6_err_clr", b_err, 1'b0);
        chk("t6_vld", b_ovld, 1'b1);
        chk("t6_data", b_odata, 8'hB1);
        chk("t6_ch", b_och, 2'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
